// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate both ways, parallel load, clear, word framing counter.
// Latency: q, shift_cnt and word_done update one cycle after the sampling edge.
// Backpressure: none; en=0 freezes q and shift_cnt (word_done drops) for as long as it is low.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en, mode          operation enable and 3-bit operation select
//   sin_lsb, sin_msb  serial inputs for SHL (enters bit 0) and SHR (enters bit WIDTH-1)
//   pin               parallel load data
//   q                 registered contents; sout_msb/sout_lsb are its end bits
//   shift_cnt         shift events since the last load/clear/wrap
//   word_done         one-cycle strobe, high while q holds a completed WIDTH-shift word
module univ_shift_reg #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    // Last count value before a wrap; the word is complete on the shift that leaves this value.
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_nxt;
    logic             shift_evt;
    logic             restart;

    // Next-state data path. Each arm reads only the inputs its mode uses, so an
    // undriven serial or parallel input cannot leak into q in an unrelated mode.
    always_comb begin
        q_nxt     = q;
        shift_evt = 1'b0;
        restart   = 1'b0;
        case (mode)
            MODE_HOLD: ;
            MODE_SHL: begin
                q_nxt     = {q[WIDTH-2:0], sin_lsb};
                shift_evt = 1'b1;
            end
            MODE_SHR: begin
                q_nxt     = {sin_msb, q[WIDTH-1:1]};
                shift_evt = 1'b1;
            end
            MODE_ROL: begin
                q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
                shift_evt = 1'b1;
            end
            MODE_ROR: begin
                q_nxt     = {q[0], q[WIDTH-1:1]};
                shift_evt = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt   = pin;
                restart = 1'b1;
            end
            MODE_CLR: begin
                q_nxt   = RST_VAL;
                restart = 1'b1;
            end
            default: ; // reserved code holds like HOLD
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= RST_VAL;
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else begin
            // Strobe defaults low so it can only ever last the one cycle after a wrap.
            word_done <= 1'b0;
            if (en) begin
                q <= q_nxt;
                if (restart) begin
                    // A load/clear on the would-be wrap cycle wins: framing restarts, no strobe.
                    shift_cnt <= '0;
                end else if (shift_evt) begin
                    if (shift_cnt == CNT_MAX) begin
                        shift_cnt <= '0;
                        word_done <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       sin_lsb;
    logic       sin_msb;
    logic [7:0] pin;

    // dut 0: WIDTH=4 RST_VAL=0, dut 1: WIDTH=4 RST_VAL=A, dut 2: WIDTH=8 RST_VAL=0
    logic [3:0] q0, q1;
    logic [7:0] q2;
    logic [1:0] c0, c1;
    logic [2:0] c2;
    logic       m0, m1, m2, l0, l1, l2, w0, w1, w2;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4), .RST_VAL(4'h0)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .pin(pin[3:0]), .q(q0), .sout_msb(m0), .sout_lsb(l0), .shift_cnt(c0), .word_done(w0));

    univ_shift_reg #(.WIDTH(4), .RST_VAL(4'hA)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .pin(pin[3:0]), .q(q1), .sout_msb(m1), .sout_lsb(l1), .shift_cnt(c1), .word_done(w1));

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .pin(pin), .q(q2), .sout_msb(m2), .sout_lsb(l2), .shift_cnt(c2), .word_done(w2));

    typedef struct {
        int         d;
        logic [7:0] q;
        int         c;
        logic       wd;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                           ROR = 3'd4, LOAD = 3'd5, CLR = 3'd6, RSV = 3'd7;

    // Drive one cycle of stimulus, then queue the state expected after that edge.
    task automatic step(input int d, input logic r, input logic e, input logic [2:0] m,
                        input logic sl, input logic sm, input logic [7:0] p,
                        input logic [7:0] eq, input int ec, input logic ewd, input string nm);
        exp_t x;
        rst = r; en = e; mode = m; sin_lsb = sl; sin_msb = sm; pin = p;
        @(posedge clk);
        x.d = d; x.q = eq; x.c = ec; x.wd = ewd; x.nm = nm;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: every negedge, compare the DUT against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t x;
                logic [7:0] aq;
                int         ac;
                logic       awd, amsb, alsb, emsb, elsb;
                x = exp_q.pop_front();
                case (x.d)
                    0:       begin aq = {4'h0, q0}; ac = int'(c0); awd = w0; amsb = m0; alsb = l0; end
                    1:       begin aq = {4'h0, q1}; ac = int'(c1); awd = w1; amsb = m1; alsb = l1; end
                    default: begin aq = q2;         ac = int'(c2); awd = w2; amsb = m2; alsb = l2; end
                endcase
                emsb = (x.d == 2) ? x.q[7] : x.q[3];
                elsb = x.q[0];
                n_vec++;
                if (aq !== x.q || ac != x.c || awd !== x.wd || amsb !== emsb || alsb !== elsb) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: got q=%h cnt=%0d wd=%b msb=%b lsb=%b, want q=%h cnt=%0d wd=%b msb=%b lsb=%b",
                             x.nm, x.d, aq, ac, awd, amsb, alsb, x.q, x.c, x.wd, emsb, elsb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; mode = HOLD; sin_lsb = 1'b0; sin_msb = 1'b0; pin = 8'h00;

        // 1: reset, then SHL 1,1,0,1 (sin_msb undriven to show it is ignored)
        step(0, 1, 0, HOLD, 0, 0,    8'h00, 8'h0, 0, 0, "t1_rst");
        step(0, 0, 1, SHL,  1, 1'bx, 8'hxx, 8'h1, 1, 0, "t1_shl1");
        step(0, 0, 1, SHL,  1, 1'bx, 8'hxx, 8'h3, 2, 0, "t1_shl2");
        step(0, 0, 1, SHL,  0, 1'bx, 8'hxx, 8'h6, 3, 0, "t1_shl3");
        step(0, 0, 1, SHL,  1, 1'bx, 8'hxx, 8'hD, 0, 1, "t1_shl4_done");

        // 2: LOAD 1011, ROL x4 with serial inputs undriven, ROR x1
        step(0, 0, 1, LOAD, 0,    0,    8'h0B, 8'hB, 0, 0, "t2_load");
        step(0, 0, 1, ROL,  1'bx, 1'bx, 8'hxx, 8'h7, 1, 0, "t2_rol1");
        step(0, 0, 1, ROL,  1'bx, 1'bx, 8'hxx, 8'hE, 2, 0, "t2_rol2");
        step(0, 0, 1, ROL,  1'bx, 1'bx, 8'hxx, 8'hD, 3, 0, "t2_rol3");
        step(0, 0, 1, ROL,  1'bx, 1'bx, 8'hxx, 8'hB, 0, 1, "t2_rol4_done");
        step(0, 0, 1, ROR,  1'bx, 1'bx, 8'hxx, 8'hD, 1, 0, "t2_ror");

        // 3: LOAD 1000, SHR sin_msb=0 x3 (sin_lsb undriven)
        step(0, 0, 1, LOAD, 0,    0, 8'h08, 8'h8, 0, 0, "t3_load");
        step(0, 0, 1, SHR,  1'bx, 0, 8'hxx, 8'h4, 1, 0, "t3_shr1");
        step(0, 0, 1, SHR,  1'bx, 0, 8'hxx, 8'h2, 2, 0, "t3_shr2");
        step(0, 0, 1, SHR,  1'bx, 0, 8'hxx, 8'h1, 3, 0, "t3_shr3");

        // 4: interrupted word, en=0 with mode toggling, then resume
        step(0, 0, 1, CLR,  0, 0, 8'h00, 8'h0, 0, 0, "t4_clr");
        step(0, 0, 1, SHL,  1, 0, 8'h00, 8'h1, 1, 0, "t4_shl1");
        step(0, 0, 1, SHL,  0, 0, 8'h00, 8'h2, 2, 0, "t4_shl2");
        step(0, 0, 0, LOAD, 1, 1, 8'hFF, 8'h2, 2, 0, "t4_frz_load");
        step(0, 0, 0, CLR,  1, 1, 8'hFF, 8'h2, 2, 0, "t4_frz_clr");
        step(0, 0, 0, SHL,  1, 1, 8'hFF, 8'h2, 2, 0, "t4_frz_shl");
        step(0, 0, 1, SHL,  1, 0, 8'h00, 8'h5, 3, 0, "t4_shl3");
        step(0, 0, 1, SHL,  1, 0, 8'h00, 8'hB, 0, 1, "t4_shl4_done");
        // rst mid-word at cnt=2
        step(0, 0, 1, SHL,  1, 0, 8'h00, 8'h7, 1, 0, "t4b_shl1");
        step(0, 0, 1, SHL,  0, 0, 8'h00, 8'hE, 2, 0, "t4b_shl2");
        step(0, 1, 1, SHL,  1, 0, 8'h00, 8'h0, 0, 0, "t4b_rst");
        step(0, 0, 1, HOLD, 1, 1, 8'hFF, 8'h0, 0, 0, "t4b_hold");

        // 5: reserved/HOLD keep state, LOAD on wrap cycle suppresses strobe
        step(0, 0, 1, LOAD, 0, 0, 8'h06, 8'h6, 0, 0, "t5_load");
        step(0, 0, 1, SHL,  0, 0, 8'h00, 8'hC, 1, 0, "t5_shl1");
        step(0, 0, 1, RSV,  1, 1, 8'hFF, 8'hC, 1, 0, "t5_rsv");
        step(0, 0, 1, HOLD, 1, 1, 8'hFF, 8'hC, 1, 0, "t5_hold");
        step(0, 0, 1, SHL,  1, 0, 8'h00, 8'h9, 2, 0, "t5_shl2");
        step(0, 0, 1, SHL,  1, 0, 8'h00, 8'h3, 3, 0, "t5_shl3");
        step(0, 0, 1, LOAD, 0, 0, 8'h05, 8'h5, 0, 0, "t5_load_at_wrap");
        step(0, 0, 1, SHL,  0, 0, 8'h00, 8'hA, 1, 0, "t5_shl_after");
        // non-zero RST_VAL on reset and on CLR
        step(1, 1, 0, HOLD, 0, 0, 8'h00, 8'hA, 0, 0, "t5_rstval");
        step(1, 0, 1, LOAD, 0, 0, 8'h03, 8'h3, 0, 0, "t5_load3");
        step(1, 0, 1, SHL,  0, 0, 8'h00, 8'h6, 1, 0, "t5_shl");
        step(1, 0, 1, CLR,  1, 1, 8'hFF, 8'hA, 0, 0, "t5_clr_rstval");

        // 6: WIDTH=8, shift in A5 MSB first
        step(2, 1, 0, HOLD, 0, 0, 8'h00, 8'h00, 0, 0, "t6_rst");
        step(2, 0, 1, SHL,  1, 0, 8'h00, 8'h01, 1, 0, "t6_b7");
        step(2, 0, 1, SHL,  0, 0, 8'h00, 8'h02, 2, 0, "t6_b6");
        step(2, 0, 1, SHL,  1, 0, 8'h00, 8'h05, 3, 0, "t6_b5");
        step(2, 0, 1, SHL,  0, 0, 8'h00, 8'h0A, 4, 0, "t6_b4");
        step(2, 0, 1, SHL,  0, 0, 8'h00, 8'h14, 5, 0, "t6_b3");
        step(2, 0, 1, SHL,  1, 0, 8'h00, 8'h29, 6, 0, "t6_b2");
        step(2, 0, 1, SHL,  0, 0, 8'h00, 8'h52, 7, 0, "t6_b1");
        step(2, 0, 1, SHL,  1, 0, 8'h00, 8'hA5, 0, 1, "t6_b0_done");
        step(2, 0, 1, SHL,  0, 0, 8'h00, 8'h4A, 1, 0, "t6_next");
        step(2, 0, 1, ROR,  1, 1, 8'h00, 8'h25, 2, 0, "t6_ror");

        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
